// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic datapath (multiplier and divider).
package fixed_point_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;

  typedef logic [WIDTH-1:0] q16_16_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam q16_16_t Q_ONE = 32'h0001_0000;
  localparam q16_16_t Q_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step_restoring.sv
// One restoring-division iteration: shift a dividend bit into the remainder,
// trial-subtract the divisor and keep either the difference or the shifted value.
module div_step_restoring #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;

  // The remainder is always below the divisor, so 2*rem+bit fits in WIDTH+1
  // bits and the MSB of a WIDTH+2-bit difference is a valid borrow/sign bit.
  assign trial   = {rem_in, bit_in} - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];
  assign rem_out = q_bit ? trial[WIDTH:0] : {rem_in[WIDTH-1:0], bit_in};

endmodule

// File: rtl/division_punto_fijo_seq.sv
// Sequential unsigned fixed-point divider: q = (a << FRAC) / b, one quotient
// bit per clock, with start/busy/done handshake and saturating flags.
module division_punto_fijo_seq
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             overflow,
  output logic             div_zero
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  div_state_t       state, state_nx;
  logic [N-1:0]     dividend;
  logic [N-1:0]     quot;
  logic [N-1:0]     quot_nx;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic [CW-1:0]    count;
  logic             last_iter;
  logic             b_zero;

  div_step_restoring #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (dividend[N-1]),
    .divisor (divisor),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  assign quot_nx   = {quot[N-2:0], step_bit};
  assign last_iter = (count == CW'(1));
  assign b_zero    = (b == '0);
  assign busy      = (state == CALC);
  assign done      = (state == DONE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; DONE always returns to IDLE so a held start waits one cycle.
  // NOTE: state_nx gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = b_zero ? DONE : CALC;
      CALC:    if (last_iter) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring iteration per CALC cycle, result update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      count    <= '0;
      q        <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (b_zero) begin
              q        <= '1;
              overflow <= 1'b0;
              div_zero <= 1'b1;
            end else begin
              dividend <= {a, {FRAC{1'b0}}};
              divisor  <= b;
              rem      <= '0;
              quot     <= '0;
              count    <= CW'(N);
            end
          end
        end
        CALC: begin
          dividend <= dividend << 1;
          rem      <= step_rem;
          quot     <= quot_nx;
          count    <= count - 1'b1;
          if (last_iter) begin
            // Any set bit above WIDTH means the true quotient does not fit.
            if (|quot_nx[N-1:WIDTH]) begin
              q        <= '1;
              overflow <= 1'b1;
            end else begin
              q        <= quot_nx[WIDTH-1:0];
              overflow <= 1'b0;
            end
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division_punto_fijo_seq.sv
// Self-checking bench for division_punto_fijo_seq: a timeline/arithmetic model
// checked every cycle, plus directed cases with hand-computed literals.
module tb_division_punto_fijo_seq;
  import fixed_point_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, overflow, div_zero;
  logic [31:0] q;

  int checks = 0;
  int errors = 0;

  division_punto_fijo_seq #(.WIDTH(32), .FRAC(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .overflow (overflow),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference for one division.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rq, output bit ov, output bit dz);
    logic [63:0] full;
    if (y == 32'h0) begin
      rq = 32'hFFFF_FFFF; ov = 1'b0; dz = 1'b1;
    end else begin
      full = ({32'h0, x} << 16) / {32'h0, y};
      dz = 1'b0;
      if (full > 64'h0000_0000_FFFF_FFFF) begin
        rq = 32'hFFFF_FFFF; ov = 1'b1;
      end else begin
        rq = full[31:0]; ov = 1'b0;
      end
    end
  endfunction

  // Transaction timeline model: which edge accepted, which edge completes.
  int unsigned edge_n = 0;
  bit          m_valid = 1'b0;
  int unsigned m_acc = 0, m_due = 0;
  logic [31:0] m_q = '0;
  bit          m_ov = 1'b0, m_dz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
    end else begin
      edge_n++;
      if (start && (!m_valid || edge_n >= m_due + 2)) begin
        ref_div(a, b, m_q, m_ov, m_dz);
        m_acc   = edge_n;
        m_due   = (b == 32'h0) ? edge_n : edge_n + 48;
        m_valid = 1'b1;
      end
    end
  end

  // Compare process: outputs checked on every falling edge.
  logic [31:0] shown_q  = '0;
  bit          shown_ov = 1'b0, shown_dz = 1'b0;
  bit          exp_done, exp_busy;

  always @(negedge clk) begin
    if (!rst_n) begin
      shown_q = '0; shown_ov = 1'b0; shown_dz = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", q, 0);
      check("rst_ovf", overflow, 0);
      check("rst_dz", div_zero, 0);
    end else begin
      exp_done = m_valid && (edge_n == m_due);
      exp_busy = m_valid && !m_dz && (edge_n >= m_acc) && (edge_n < m_due);
      check("mdl_done", done, exp_done);
      check("mdl_busy", busy, exp_busy);
      if (exp_done) begin
        shown_q = m_q; shown_ov = m_ov; shown_dz = m_dz;
      end
      check("mdl_q", q, shown_q);
      check("mdl_ovf", overflow, shown_ov);
      check("mdl_dz", div_zero, shown_dz);
    end
  end

  // One operation from IDLE: pulse start, scramble operands, wait for done, compare.
  task automatic do_op(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_q, input bit exp_ov, input bit exp_dz);
    int lat;
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, lat, (y == 32'h0) ? 1 : 49);
    check({name, "_q"}, q, exp_q);
    check({name, "_ovf"}, overflow, exp_ov);
    check({name, "_dz"}, div_zero, exp_dz);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_seen"}, done, 1);
  endtask

  initial begin
    logic [31:0] rx, ry, rq;
    bit rov, rdz;
    int k;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-computed results.
    do_op("six_by_two", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 0, 0);
    do_op("frac",       32'h0001_8000, 32'h0003_4000, 32'h0000_7627, 0, 0);
    do_op("tiny",       32'h0000_0001, 32'h0002_0000, 32'h0000_0000, 0, 0);
    do_op("ovf",        32'h7FFF_0000, 32'h0000_0100, Q_SAT,         1, 0);
    do_op("zero_div",   32'h1234_5678, 32'h0000_0000, Q_SAT,         0, 1);
    do_op("one",        32'h0005_0000, 32'h0005_0000, Q_ONE,         0, 0);

    // Start pulsed mid-division with new operands must be ignored.
    @(posedge clk); #1;
    a = 32'h000A_0000; b = 32'h0004_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    a = 32'h0000_0001; b = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    wait_done("ignore");
    check("ignore_q", q, 32'h0002_8000);

    // Start held high: results arrive every N+2 = 50 cycles.
    @(posedge clk); #1;
    a = 32'h0003_0000; b = 32'h0002_0000; start = 1'b1;
    @(negedge clk);
    wait_done("held_first");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 200);
    check("held_period", k, 50);
    check("held_q", q, 32'h0001_8000);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset at iteration 20 aborts the division.
    @(posedge clk); #1;
    a = 32'h0009_0000; b = 32'h0002_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", q, 0);
    check("arst_ovf", overflow, 0);
    check("arst_dz", div_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    do_op("after_rst", 32'h0009_0000, 32'h0002_0000, 32'h0004_8000, 0, 0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      case ($urandom_range(0, 9))
        0:       ry = 32'h0;
        1, 2, 3: ry = $urandom_range(1, 255);
        default: ry = $urandom;
      endcase
      ref_div(rx, ry, rq, rov, rdz);
      do_op("rand", rx, ry, rq, rov, rdz);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/division_punto_fijo_seq.md
Name: division_punto_fijo_seq

Overview:
- Sequential unsigned fixed-point divider, Q16.16 operands and result; the inverse operation of the team's combinational fixed-point multiplier.
- Computes q = (A << FRAC) / B by restoring division, one quotient bit per clock.
- Uses a start/busy/done handshake and sits beside the multiplier in the arithmetic datapath.
- Trades latency for area: no wide combinational divider.

Parameters:
WIDTH, 32, operand and result width in bits
FRAC, 16, fractional bits of operands and result (Q(WIDTH-FRAC).FRAC)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  dividend, unsigned Q16.16
b  input  WIDTH  divisor, unsigned Q16.16
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when q and flags become valid
q  output  WIDTH  quotient, unsigned Q16.16, truncated toward zero
overflow  output  1  true quotient exceeds WIDTH bits; q saturated
div_zero  output  1  b was zero; q saturated

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low forces state IDLE immediately and zeroes all registers.
  - busy=0, done=0, q=0, overflow=0, div_zero=0.
  - Reset mid-division aborts the operation; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - On a clock edge with start=1 and b!=0:
    - Capture the dividend register as {a, FRAC zeros} (N = WIDTH+FRAC = 48 bits).
    - Capture b.
    - Clear the remainder (WIDTH+1 bits) and the quotient shift register (N bits).
    - Set count=N and go to CALC.
  - On start=1 with b==0: go to DONE with q=all ones, div_zero=1, overflow=0.
  - q and flags from the previous operation stay stable until that accepting edge.
- CALC (busy=1), each cycle:
  - Shift the dividend MSB into the remainder.
  - Trial-subtract b. If the result is non-negative, keep the difference and shift quotient bit 1; otherwise restore and shift 0.
  - Decrement count. Leave CALC after the N-th iteration.
- Exiting CALC:
  - If quotient[N-1:WIDTH] != 0: q=all ones, overflow=1. Otherwise q=quotient[WIDTH-1:0], overflow=0.
  - div_zero=0.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start high during DONE is ignored.
- Latency:
  - Normal operation: done is high in the cycle following the 49th edge after the accepting edge (N iterations + 1).
  - Divide by zero: done is high in the cycle following the accepting edge.
- Back-to-back: start may be held high. A new operation is accepted on the first edge in IDLE after DONE, so throughput is one result per N+2 cycles.
- start is ignored while busy, and operands are not re-sampled. a and b may change freely after the accepting edge.
- Rounding is truncation. No remainder output.
- Arithmetic is unsigned only. Signed wrappers belong outside this block.

Decomposition:
- Shared package fixed_point_pkg:
  - WIDTH=32, FRAC=16.
  - Typedef q16_16_t (logic [31:0]).
  - Enum div_state_t {IDLE, CALC, DONE}.
  - Constant Q_ONE = 32'h0001_0000.
  - Constant Q_SAT = 32'hFFFF_FFFF.
  - The multiplier imports the same package.
- One natural sub-module: div_step_restoring. It is combinational, handles one remainder shift/subtract/select, and is instantiated once and iterated by the FSM.

Test Plan:
- a=0x0006_0000, b=0x0002_0000, start 1 cycle -> busy for 48 cycles; done at edge 49 with q=0x0003_0000, overflow=0, div_zero=0.
- a=0x0001_8000 (1.5), b=0x0003_4000 (3.25) -> q=0x0000_7627 (truncated 0.4615). Also a=0x0000_0001, b=0x0002_0000 -> q=0.
- a=0x7FFF_0000, b=0x0000_0100 -> overflow=1, q=0xFFFF_FFFF, div_zero=0.
- b=0, a=0x1234_5678 -> done one cycle after accept, div_zero=1, q=0xFFFF_FFFF, busy never high.
- Start pulsed with new operands at cycle 10 of a running division -> ignored; the first result is unchanged. Start held high continuously -> next accept on the edge after DONE.
- rst_n low at iteration 20 -> busy, done, q and flags all 0 asynchronously; no done pulse. After release, a fresh start yields a correct result.
